// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC front end: default sample/frame geometry
// used by both the frame scheduler and the window stage, plus the frame
// scheduler state encoding and buffer sizing helpers.
package mfcc_pkg;

  localparam int Q_IN_DEF   = 15;
  localparam int N_DEF      = 256;
  localparam int HOP_DEF    = 128;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    OFFER,
    STREAM,
    DRAIN
  } frame_sched_state_t;

  // Ring buffer depth for a given address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Occupancy needs one extra bit so that a full buffer (occ == depth)
  // is distinguishable from an empty one.
  function automatic int occ_width_of(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/frame_ring_ram.sv
// Simple dual-port sample RAM for the frame scheduler ring buffer:
// one write port, one synchronous-read port, no reset on contents.
module frame_ring_ram
  import mfcc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WIDTH  = Q_IN_DEF + 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]  rd_data
);

  logic signed [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port share the single clock.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler for the MFCC window stage. Buffers the sample stream in a
// ring buffer, cuts overlapping frames of N samples advancing by HOP, offers
// each frame with a level-held packet flag and serves one sample per request
// assertion. Optional build macro FRAME_SCHED_INDEX_EN adds frame_index and
// frame_last_dropped outputs.
module frame_scheduler
  import mfcc_pkg::*;
#(
  parameter int Q_IN   = Q_IN_DEF,
  parameter int N      = N_DEF,
  parameter int HOP    = HOP_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic signed [Q_IN:0]  sample_in,
  input  logic                  win_valid_request,
  output logic                  win_valid_packet,
  output logic                  win_valid_in,
  output logic signed [Q_IN:0]  win_data,
  output logic                  busy,
  output logic                  overflow
`ifdef FRAME_SCHED_INDEX_EN
  ,
  output logic [15:0]           frame_index,
  output logic                  frame_last_dropped
`endif
);

  localparam int D     = depth_of(ADDR_W);
  localparam int OCC_W = occ_width_of(ADDR_W);
  localparam int IDX_W = $clog2(N + 1);
  localparam logic [OCC_W-1:0] D_OCC   = OCC_W'(D);
  localparam logic [OCC_W-1:0] N_OCC   = OCC_W'(N);
  localparam logic [OCC_W-1:0] HOP_OCC = OCC_W'(HOP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (D < N + HOP) begin : g_depth_chk
    $error("frame_scheduler: ring buffer depth must be at least N+HOP");
  end
  if (HOP < 1 || HOP > N) begin : g_hop_chk
    $error("frame_scheduler: HOP must lie in 1..N");
  end

  frame_sched_state_t state, state_next;

  // Pointers carry one bit beyond the RAM address so occupancy reaches D.
  logic [OCC_W-1:0]       wr_ptr, rd_base, occ, occ_after_hop;
  logic [IDX_W-1:0]       idx;
  logic                   armed;
  logic                   wr_en, drop, serve, last_serve, hop_done;
  logic [ADDR_W-1:0]      rd_addr;
  logic signed [Q_IN:0]   ram_q_p1;

  assign occ           = wr_ptr - rd_base;
  assign occ_after_hop = wr_ptr - (rd_base + HOP_OCC);
  assign wr_en         = sample_valid && enable && (occ < D_OCC);
  assign drop          = sample_valid && enable && (occ == D_OCC);
  assign serve         = (state == STREAM) && win_valid_request && armed;
  assign last_serve    = serve && (idx == LAST_IDX);
  assign hop_done      = (state == DRAIN) && !win_valid_request;
  // Read address tracks the next sample so its data is ready before the request.
  assign rd_addr       = rd_base[ADDR_W-1:0] + ADDR_W'(idx);

  assign win_valid_packet = (state == OFFER);
  assign busy             = (state == OFFER) || (state == STREAM) || (state == DRAIN);

  frame_ring_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (Q_IN + 1)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (sample_in),
    .rd_addr (rd_addr),
    .rd_data (ram_q_p1)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; an offered frame always runs through DRAIN even if enable drops.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (enable) state_next = FILL;
      FILL: begin
        if (!enable)              state_next = IDLE;
        else if (occ >= N_OCC)    state_next = OFFER;
      end
      OFFER:  if (win_valid_request) state_next = STREAM;
      STREAM: if (last_serve) state_next = DRAIN;
      DRAIN: begin
        if (hop_done) begin
          if (!enable)                      state_next = IDLE;
          else if (occ_after_hop >= N_OCC)  state_next = OFFER;
          else                              state_next = FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write pointer and frame base; both parked at zero while idle and disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_base <= '0;
    end else if (state == IDLE && !enable) begin
      wr_ptr  <= '0;
      rd_base <= '0;
    end else begin
      if (wr_en)    wr_ptr  <= wr_ptr + OCC_W'(1);
      if (hop_done) rd_base <= rd_base + HOP_OCC;
    end
  end

  // Sample index within the frame and the one-serve-per-request arm flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      armed <= 1'b1;
    end else begin
      if (state == OFFER || hop_done) idx <= '0;
      else if (serve)                 idx <= idx + IDX_W'(1);
      if (!win_valid_request) armed <= 1'b1;
      else if (serve)         armed <= 1'b0;
    end
  end

  // Output stage: one-cycle valid pulse, data held between pulses, sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_valid_in <= 1'b0;
      win_data     <= '0;
      overflow     <= 1'b0;
    end else begin
      win_valid_in <= serve;
      if (serve) win_data <= ram_q_p1;
      if (drop)  overflow <= 1'b1;
    end
  end

`ifdef FRAME_SCHED_INDEX_EN
  logic drop_seen;

  // Frame numbering and drop tagging, updated only at frame boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_index        <= '0;
      frame_last_dropped <= 1'b0;
      drop_seen          <= 1'b0;
    end else begin
      if (hop_done) frame_index <= frame_index + 16'd1;
      if (state != OFFER && state_next == OFFER) begin
        frame_last_dropped <= drop_seen | drop;
        drop_seen          <= 1'b0;
      end else if (drop) begin
        drop_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler (default build, N=256, HOP=128, D=512).
module tb_frame_scheduler;
  localparam int Q_IN = 15, N = 256, HOP = 128, ADDR_W = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [Q_IN:0] sample_in = '0;
  logic win_valid_request = 1'b0;
  logic win_valid_packet, win_valid_in, busy, overflow;
  logic signed [Q_IN:0] win_data;

  int tests = 0;
  int fails = 0;
  int cap_n = 0;
  logic signed [Q_IN:0] cap [0:4095];

  frame_scheduler #(.Q_IN(Q_IN), .N(N), .HOP(HOP), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .sample_valid      (sample_valid),
    .sample_in         (sample_in),
    .win_valid_request (win_valid_request),
    .win_valid_packet  (win_valid_packet),
    .win_valid_in      (win_valid_in),
    .win_data          (win_data),
    .busy              (busy),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  // Capture every served sample in arrival order.
  always @(negedge clk) begin
    if (win_valid_in === 1'b1) begin
      if (cap_n < 4096) cap[cap_n] = win_data;
      cap_n = cap_n + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    sample_valid = 1'b0;
    win_valid_request = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic feed(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = 16'(base + i);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_packet(input string tag);
    int k = 0;
    while (win_valid_packet !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(win_valid_packet), 32'd1);
  endtask

  // Window stage model: request held for three cycles, then one low cycle.
  task automatic serve(input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk); win_valid_request = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); win_valid_request = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int start, input int base, output int sum);
    int bad = 0;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      if (cap[start + i] !== 16'(base + i)) bad++;
      sum += int'(cap[start + i]);
    end
    check({tag, "_count"}, cap_n - start, N);
    check({tag, "_data_errors"}, bad, 0);
  endtask

  initial begin
    int s, sum, held;

    // Reset state
    idle(3);
    check("rst_packet", 32'(win_valid_packet), 0);
    check("rst_valid_in", 32'(win_valid_in), 0);
    check("rst_data", 32'(win_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Ramp 0..383, window stalled until all samples are in
    reset_n = 1'b1;
    enable = 1'b1;
    feed(0, 384);
    wait_packet("f0_packet");
    check("f0_busy", 32'(busy), 1);
    held = 0;
    repeat (20) begin
      @(negedge clk);
      if (win_valid_packet === 1'b1) held++;
    end
    check("f0_packet_held", held, 20);
    s = cap_n;
    serve(N);
    idle(4);
    check_frame("f0", s, 0, sum);
    check("f0_checksum", sum, 32640);

    // Second frame overlaps by HOP
    wait_packet("f1_packet");
    s = cap_n;
    serve(N);
    idle(4);
    check_frame("f1", s, 128, sum);
    check("f1_after_busy", 32'(busy), 0);
    check("f1_after_packet", 32'(win_valid_packet), 0);
    check("f1_no_overflow", 32'(overflow), 0);

    // Overflow: 512 samples fill the buffer, the next one is dropped
    do_reset();
    enable = 1'b1;
    feed(0, 512);
    check("ovf_full_no_flag", 32'(overflow), 0);
    feed(512, 1);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_wr_ptr", 32'(dut.wr_ptr), 512);
    wait_packet("ovf_packet");
    s = cap_n;
    serve(N);
    idle(4);
    check_frame("ovf", s, 0, sum);
    check("ovf_sticky", 32'(overflow), 1);

    // enable dropped mid-frame
    do_reset();
    enable = 1'b1;
    feed(0, 256);
    wait_packet("en_packet");
    s = cap_n;
    serve(100);
    enable = 1'b0;
    feed(1000, 10);
    check("en_writes_stopped", 32'(dut.wr_ptr), 256);
    check("en_busy_mid", 32'(busy), 1);
    serve(156);
    idle(4);
    check_frame("en", s, 0, sum);
    check("en_busy_after", 32'(busy), 0);
    check("en_packet_after", 32'(win_valid_packet), 0);
    check("en_wr_ptr_zero", 32'(dut.wr_ptr), 0);
    check("en_rd_base_zero", 32'(dut.rd_base), 0);

    // Async reset mid-STREAM, then reframe from scratch
    enable = 1'b1;
    feed(0, 256);
    wait_packet("ar_packet");
    serve(50);
    @(negedge clk); win_valid_request = 1'b1;
    @(negedge clk);
    check("ar_pre_pulse", 32'(win_valid_in), 1);
    check("ar_pre_data", 32'(win_data), 50);
    #1 reset_n = 1'b0;
    #1;
    check("ar_valid_in", 32'(win_valid_in), 0);
    check("ar_data", 32'(win_data), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_packet", 32'(win_valid_packet), 0);
    check("ar_overflow", 32'(overflow), 0);
    win_valid_request = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    feed(0, 256);
    wait_packet("ar_new_packet");
    s = cap_n;
    serve(N);
    idle(4);
    check_frame("ar_new", s, 0, sum);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
